trap_sequencer: RTL and testbench

//  Machine-mode trap controller for the 5-stage RV32 pipeline. It takes synchronous exceptions
//  (illegal instruction, ECALL) and interrupts (external, timer) at the EX stage. It freezes and

---
 rtl/trap_sequencer_if.sv | 47 ++++
 rtl/trap_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_trap_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus bundle.
// Groups the EX-stage trap requests, the CSR snapshot, the CSR write port,
// the pipeline control strobes and the debug state of trap_sequencer.
//   slave  : the sequencer's view (i_* in, o_* out)
//   master : the pipeline/testbench view (i_* out, o_* in)
// Handshake: there is no valid/ready pair. A request is taken only on a
// rising clk edge where the sequencer is idle (o_busy=0) and i_valid_e=1,
// i_mret_e=0 and at least one enabled cause is present. Requests arriving
// while o_busy=1 are dropped and never queued.
interface trap_sequencer_if #(
   parameter int XLEN = 32
);
   logic            i_valid_e;
   logic [XLEN-1:0] i_pc_e;
   logic            i_illegal_e;
   logic            i_ecall_e;
   logic            i_mret_e;
   logic            i_irq_ext;
   logic            i_irq_timer;
   logic [XLEN-1:0] i_mstatus;
   logic [XLEN-1:0] i_mie;
   logic [XLEN-1:0] i_mtvec;
   logic            i_csr_inflight;
   logic            o_pc_stall;
   logic            o_flush_all;
   logic            o_csr_we;
   logic [11:0]     o_csr_addr;
   logic [XLEN-1:0] o_csr_wdata;
   logic            o_redirect;
   logic [XLEN-1:0] o_redirect_pc;
   logic            o_busy;
   logic [2:0]      o_state;     // debug: current sequencer state

   modport slave (
      input  i_valid_e, i_pc_e, i_illegal_e, i_ecall_e, i_mret_e,
      input  i_irq_ext, i_irq_timer, i_mstatus, i_mie, i_mtvec, i_csr_inflight,
      output o_pc_stall, o_flush_all, o_csr_we, o_csr_addr, o_csr_wdata,
      output o_redirect, o_redirect_pc, o_busy, o_state
   );

   modport master (
      output i_valid_e, i_pc_e, i_illegal_e, i_ecall_e, i_mret_e,
      output i_irq_ext, i_irq_timer, i_mstatus, i_mie, i_mtvec, i_csr_inflight,
      input  o_pc_stall, o_flush_all, o_csr_we, o_csr_addr, o_csr_wdata,
      input  o_redirect, o_redirect_pc, o_busy, o_state
   );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer for the 5-stage RV32 pipeline.
// Takes an illegal-instruction / ECALL exception or an enabled external /
// timer interrupt at EX, freezes and flushes the front end, waits for CSR
// writers in MEM/WB to retire, writes mepc, mcause and mstatus, then
// redirects fetch to mtvec (vectored for interrupts when mtvec mode = 1).
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous reset, active low
//   bus     : trap_sequencer_if.slave (requests, CSR snapshot, CSR write
//             port, stall/flush/redirect strobes, busy, debug state)
// All outputs are registered copies of a decode of the current state, so
// each output appears one cycle after the state that produces it.
module trap_sequencer #(
   parameter int          XLEN         = 32,
   parameter logic [11:0] MSTATUS_ADDR = 12'h300,
   parameter logic [11:0] MEPC_ADDR    = 12'h341,
   parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
   input logic             i_clk,
   input logic             i_rst_n,
   trap_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      DRAIN    = 3'd1,
      W_EPC    = 3'd2,
      W_CAUSE  = 3'd3,
      W_STATUS = 3'd4,
      REDIRECT = 3'd5
   } state_t;

   localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
   localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);
   localparam logic [XLEN-1:0] CAUSE_EXT     = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
   localparam logic [XLEN-1:0] CAUSE_TIMER   = {1'b1, {(XLEN-4){1'b0}}, 3'h7};

   state_t          state, state_next;

   // Trap context captured at accept
   logic [XLEN-1:0] cause_q, epc_q;
   logic            is_irq_q;

   // Registered outputs
   logic            pc_stall_q, flush_all_q, csr_we_q, redirect_q, busy_q;
   logic [11:0]     csr_addr_q;
   logic [XLEN-1:0] csr_wdata_q, redirect_pc_q;

   // Combinational decode
   logic            accept;
   logic [XLEN-1:0] take_cause;
   logic            take_irq;
   logic            ext_ok, timer_ok;
   logic            pc_stall_d, flush_all_d, csr_we_d, redirect_d, busy_d;
   logic [11:0]     csr_addr_d;
   logic [XLEN-1:0] csr_wdata_d, redirect_pc_d, status_new, vec_offset;

   // Interrupts need the global MIE bit plus their own enable in mie.
   assign ext_ok   = bus.i_irq_ext   & bus.i_mstatus[3] & bus.i_mie[11];
   assign timer_ok = bus.i_irq_timer & bus.i_mstatus[3] & bus.i_mie[7];

   // MPIE <= MIE, MIE <= 0, MPP <= M-mode
   always_comb begin
      status_new     = bus.i_mstatus;
      status_new[7]  = bus.i_mstatus[3];
      status_new[3]  = 1'b0;
      status_new[12:11] = 2'b11;
   end

   // Vectored offset is 4*cause[4:0]; only used for interrupts in mode 1.
   assign vec_offset = {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00};

   always_comb begin
      state_next    = state;
      accept        = 1'b0;
      take_cause    = '0;
      take_irq      = 1'b0;
      pc_stall_d    = 1'b0;
      flush_all_d   = 1'b0;
      csr_we_d      = 1'b0;
      csr_addr_d    = '0;
      csr_wdata_d   = '0;
      redirect_d    = 1'b0;
      redirect_pc_d = '0;
      busy_d        = 1'b0;

      case (state)
         IDLE: begin
            // busy_q still reflects REDIRECT in the first IDLE cycle, which
            // keeps the flushed slot from raising a second trap.
            if (!busy_q && bus.i_valid_e && !bus.i_mret_e) begin
               if (bus.i_illegal_e) begin
                  accept     = 1'b1;
                  take_cause = CAUSE_ILLEGAL;
               end else if (bus.i_ecall_e) begin
                  accept     = 1'b1;
                  take_cause = CAUSE_ECALL;
               end else if (ext_ok) begin
                  accept     = 1'b1;
                  take_cause = CAUSE_EXT;
                  take_irq   = 1'b1;
               end else if (timer_ok) begin
                  accept     = 1'b1;
                  take_cause = CAUSE_TIMER;
                  take_irq   = 1'b1;
               end
            end
            if (accept) state_next = DRAIN;
         end
         DRAIN: begin
            pc_stall_d  = 1'b1;
            flush_all_d = 1'b1;
            busy_d      = 1'b1;
            if (!bus.i_csr_inflight) state_next = W_EPC;
         end
         W_EPC: begin
            pc_stall_d  = 1'b1;
            flush_all_d = 1'b1;
            busy_d      = 1'b1;
            csr_we_d    = 1'b1;
            csr_addr_d  = MEPC_ADDR;
            csr_wdata_d = {epc_q[XLEN-1:2], 2'b00};
            state_next  = W_CAUSE;
         end
         W_CAUSE: begin
            pc_stall_d  = 1'b1;
            flush_all_d = 1'b1;
            busy_d      = 1'b1;
            csr_we_d    = 1'b1;
            csr_addr_d  = MCAUSE_ADDR;
            csr_wdata_d = cause_q;
            state_next  = W_STATUS;
         end
         W_STATUS: begin
            pc_stall_d  = 1'b1;
            flush_all_d = 1'b1;
            busy_d      = 1'b1;
            csr_we_d    = 1'b1;
            csr_addr_d  = MSTATUS_ADDR;
            csr_wdata_d = status_new;
            state_next  = REDIRECT;
         end
         REDIRECT: begin
            busy_d        = 1'b1;
            redirect_d    = 1'b1;
            redirect_pc_d = {bus.i_mtvec[XLEN-1:2], 2'b00};
            if (bus.i_mtvec[1:0] == 2'b01 && is_irq_q)
               redirect_pc_d = {bus.i_mtvec[XLEN-1:2], 2'b00} + vec_offset;
            state_next    = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cause_q  <= '0;
         epc_q    <= '0;
         is_irq_q <= 1'b0;
      end else if (accept) begin
         cause_q  <= take_cause;
         epc_q    <= bus.i_pc_e;
         is_irq_q <= take_irq;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc_stall_q    <= 1'b0;
         flush_all_q   <= 1'b0;
         csr_we_q      <= 1'b0;
         csr_addr_q    <= '0;
         csr_wdata_q   <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         busy_q        <= 1'b0;
      end else begin
         pc_stall_q    <= pc_stall_d;
         flush_all_q   <= flush_all_d;
         csr_we_q      <= csr_we_d;
         csr_addr_q    <= csr_addr_d;
         csr_wdata_q   <= csr_wdata_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.o_pc_stall    = pc_stall_q;
   assign bus.o_flush_all   = flush_all_q;
   assign bus.o_csr_we      = csr_we_q;
   assign bus.o_csr_addr    = csr_addr_q;
   assign bus.o_csr_wdata   = csr_wdata_q;
   assign bus.o_redirect    = redirect_q;
   assign bus.o_redirect_pc = redirect_pc_q;
   assign bus.o_busy        = busy_q;
   assign bus.o_state       = state;

   // mie bits other than MEIE/MTIE and the epc alignment bits are not needed.
   logic unused_bits;
   assign unused_bits = ^{bus.i_mie[XLEN-1:12], bus.i_mie[10:8], bus.i_mie[6:0], epc_q[1:0]};

endmodule

// File: tb/tb_trap_sequencer.sv
module tb_trap_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic [43:0] exp_q[$];   // {csr_addr, csr_wdata} in issue order

   trap_sequencer_if #(.XLEN(32)) bus ();

   trap_sequencer dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [43:0] got, input logic [43:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"},    44'(bus.o_pc_stall), 44'd0);
      check({tag, "_flush"},    44'(bus.o_flush_all), 44'd0);
      check({tag, "_we"},       44'(bus.o_csr_we), 44'd0);
      check({tag, "_addr"},     44'(bus.o_csr_addr), 44'd0);
      check({tag, "_wdata"},    44'(bus.o_csr_wdata), 44'd0);
      check({tag, "_redir"},    44'(bus.o_redirect), 44'd0);
      check({tag, "_redir_pc"}, 44'(bus.o_redirect_pc), 44'd0);
      check({tag, "_busy"},     44'(bus.o_busy), 44'd0);
      check({tag, "_state"},    44'(bus.o_state), 44'd0);
   endtask

   // ---------------- driver ----------------
   task automatic clear_requests();
      bus.i_valid_e   = 1'b0;
      bus.i_illegal_e = 1'b0;
      bus.i_ecall_e   = 1'b0;
      bus.i_mret_e    = 1'b0;
      bus.i_irq_ext   = 1'b0;
      bus.i_irq_timer = 1'b0;
   endtask

   // One request cycle followed by observation of the whole trap sequence.
   // extra    : cycles of i_csr_inflight seen by the sequencer while draining
   // rst_at   : observation cycle after which reset is pulsed (-1 = none)
   task automatic run_trial(
      input logic valid, input logic [31:0] pc,
      input logic ill, input logic ecall, input logic mret,
      input logic ext, input logic tmr,
      input logic [31:0] ms, input logic [31:0] mie, input logic [31:0] mtvec,
      input int extra, input int rst_at);
      logic        acc, irq;
      logic [31:0] cause, ms_new, target;
      logic [43:0] e;
      int          last;

      // reference model: decide the trap and its effects from the rules
      acc = 1'b0; irq = 1'b0; cause = 32'd0;
      if (valid && !mret) begin
         if (ill)                          begin acc = 1'b1; cause = 32'd2;  end
         else if (ecall)                   begin acc = 1'b1; cause = 32'd11; end
         else if (ext && ms[3] && mie[11]) begin acc = 1'b1; irq = 1'b1; cause = 32'h8000000B; end
         else if (tmr && ms[3] && mie[7])  begin acc = 1'b1; irq = 1'b1; cause = 32'h80000007; end
      end
      ms_new = ms;
      ms_new[7] = ms[3];
      ms_new[3] = 1'b0;
      ms_new[12:11] = 2'b11;
      target = mtvec & 32'hFFFF_FFFC;
      if (mtvec[1:0] == 2'b01 && irq) target = target + 32'(cause % 32) * 32'd4;
      exp_q.delete();
      if (acc) begin
         exp_q.push_back({12'h341, pc & 32'hFFFF_FFFC});
         exp_q.push_back({12'h342, cause});
         exp_q.push_back({12'h300, ms_new});
      end

      @(posedge clk); #1;
      bus.i_valid_e      = valid;
      bus.i_pc_e         = pc;
      bus.i_illegal_e    = ill;
      bus.i_ecall_e      = ecall;
      bus.i_mret_e       = mret;
      bus.i_irq_ext      = ext;
      bus.i_irq_timer    = tmr;
      bus.i_mstatus      = ms;
      bus.i_mie          = mie;
      bus.i_mtvec        = mtvec;
      bus.i_csr_inflight = (extra > 0);
      @(posedge clk); #1;   // accept edge T
      clear_requests();
      bus.i_csr_inflight = (extra > 0);

      last = 7 + extra;
      for (int c = 1; c <= last; c++) begin
         @(posedge clk); #1;
         bus.i_csr_inflight = (c < extra);
         @(negedge clk);
         check("busy",     44'(bus.o_busy),      44'(acc && c <= 5 + extra));
         check("flush",    44'(bus.o_flush_all), 44'(acc && c <= 4 + extra));
         check("pc_stall", 44'(bus.o_pc_stall),  44'(acc && c <= 4 + extra));
         check("redirect", 44'(bus.o_redirect),  44'(acc && c == 5 + extra));
         if (acc && c == 5 + extra)
            check("redirect_pc", 44'(bus.o_redirect_pc), 44'(target));
         check("csr_we", 44'(bus.o_csr_we), 44'(acc && c >= 2 + extra && c <= 4 + extra));
         if (bus.o_csr_we) begin
            if (exp_q.size() == 0) begin
               check("csr_unexpected", 44'd1, 44'd0);
            end else begin
               e = exp_q.pop_front();
               check("csr_addr",  44'(bus.o_csr_addr),  44'(e[43:32]));
               check("csr_wdata", 44'(bus.o_csr_wdata), 44'(e[31:0]));
            end
         end
         if (c == rst_at) begin
            rst_n = 1'b0;
            #2;
            check_all_zero("mid_rst");
            rst_n = 1'b1;
            acc = 1'b0;          // nothing more may follow the reset
            exp_q.delete();
         end
      end
      check("csr_pending", 44'(exp_q.size()), 44'd0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      clear_requests();
      bus.i_pc_e         = '0;
      bus.i_mstatus      = '0;
      bus.i_mie          = '0;
      bus.i_mtvec        = '0;
      bus.i_csr_inflight = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      #2 rst_n = 1'b1;

      // illegal instruction, no inflight CSR
      run_trial(1, 32'h100, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h200, 0, -1);
      // ecall beats a simultaneous enabled external interrupt
      run_trial(1, 32'h2004, 0, 1, 0, 1, 0, 32'h8, 32'h800, 32'h200, 0, -1);
      // timer interrupt through a vectored mtvec
      run_trial(1, 32'h3000, 0, 0, 0, 0, 1, 32'h8, 32'h80, 32'h401, 0, -1);
      // external interrupt masked by mstatus.MIE, then enabled
      run_trial(1, 32'h3100, 0, 0, 0, 1, 0, 32'h0, 32'h800, 32'h401, 0, -1);
      run_trial(1, 32'h3100, 0, 0, 0, 1, 0, 32'h8, 32'h800, 32'h401, 0, -1);
      // drain held by inflight CSR writers
      run_trial(1, 32'h4002, 1, 0, 0, 0, 0, 32'h1888, 32'h0, 32'h800, 2, -1);
      // reset while mcause is being sequenced
      run_trial(1, 32'h5000, 1, 0, 0, 0, 0, 32'h8, 32'h0, 32'h200, 0, 2);
      // MRET blocks acceptance
      run_trial(1, 32'h6000, 1, 0, 1, 0, 0, 32'h8, 32'h888, 32'h200, 0, -1);
      // bubble never traps
      run_trial(0, 32'h7000, 1, 1, 0, 1, 1, 32'h8, 32'h888, 32'h200, 0, -1);
      // vectored target wraps modulo 2^32
      run_trial(1, 32'h8000, 0, 0, 0, 1, 0, 32'h8, 32'h800, 32'hFFFF_FFF1, 1, -1);

      for (int n = 0; n < 40; n++) begin
         run_trial($urandom_range(0, 7) != 0, $urandom,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 7) == 0,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
